// File: rtl/uart_msg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_msg_pkg
// Description : Shared state codes, grant codes and ASCII constants for the
//               UART message scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_msg_pkg;

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_LOAD = 2'd1;
  localparam logic [1:0] c_ST_SEND = 2'd2;
  localparam logic [1:0] c_ST_GAP  = 2'd3;

  localparam logic [1:0] c_GRANT_NONE  = 2'b00;
  localparam logic [1:0] c_GRANT_TIME  = 2'b01;
  localparam logic [1:0] c_GRANT_ALARM = 2'b10;

  localparam logic [7:0] c_ASCII_COLON = 8'h3A;
  localparam logic [7:0] c_ASCII_CR    = 8'h0D;
  localparam logic [7:0] c_ASCII_LF    = 8'h0A;
  localparam logic [7:0] c_ASCII_QMARK = 8'h3F;
  localparam logic [7:0] c_ASCII_A     = 8'h41;
  localparam logic [7:0] c_ASCII_L     = 8'h4C;
  localparam logic [7:0] c_ASCII_R     = 8'h52;
  localparam logic [7:0] c_ASCII_M     = 8'h4D;
  localparam logic [7:0] c_DIGIT_BASE  = 8'h30;

  localparam int c_TIME_LEN_DEF  = 10;
  localparam int c_ALARM_LEN_DEF = 7;
  localparam int c_IDX_W         = 4;

  // Non-decimal nibbles render as '?' so a corrupt clock value is visible.
  function automatic logic [7:0] bcd_to_ascii(input logic [3:0] nibble);
    if (nibble > 4'd9) begin
      return c_ASCII_QMARK;
    end
    return c_DIGIT_BASE + {4'd0, nibble};
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_msg_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_msg_scheduler_if
// Description : Byte-level valid/ready handshake toward the UART transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_msg_scheduler_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );

endinterface
`default_nettype wire

// File: rtl/uart_msg_char.sv
`default_nettype none
// ============================================================================
// Module      : uart_msg_char
// Description : Combinational lookup of one message byte from grant and index.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_msg_char
  import uart_msg_pkg::*;
(
  input  wire logic [1:0]         grant,
  input  wire logic [c_IDX_W-1:0] index,
  input  wire logic [7:0]         hour_bcd,
  input  wire logic [7:0]         min_bcd,
  input  wire logic [7:0]         sec_bcd,
  output logic      [7:0]         char_out
);

  always_comb begin
    char_out = 8'h00;
    if (grant == c_GRANT_ALARM) begin
      case (index)
        4'd0:    char_out = c_ASCII_A;
        4'd1:    char_out = c_ASCII_L;
        4'd2:    char_out = c_ASCII_A;
        4'd3:    char_out = c_ASCII_R;
        4'd4:    char_out = c_ASCII_M;
        4'd5:    char_out = c_ASCII_CR;
        4'd6:    char_out = c_ASCII_LF;
        default: char_out = 8'h00;
      endcase
    end else if (grant == c_GRANT_TIME) begin
      case (index)
        4'd0:    char_out = bcd_to_ascii(hour_bcd[7:4]);
        4'd1:    char_out = bcd_to_ascii(hour_bcd[3:0]);
        4'd2:    char_out = c_ASCII_COLON;
        4'd3:    char_out = bcd_to_ascii(min_bcd[7:4]);
        4'd4:    char_out = bcd_to_ascii(min_bcd[3:0]);
        4'd5:    char_out = c_ASCII_COLON;
        4'd6:    char_out = bcd_to_ascii(sec_bcd[7:4]);
        4'd7:    char_out = bcd_to_ascii(sec_bcd[3:0]);
        4'd8:    char_out = c_ASCII_CR;
        4'd9:    char_out = c_ASCII_LF;
        default: char_out = 8'h00;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_msg_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : uart_msg_scheduler
// Description : Arbitrates alarm/time report requests and streams the granted
//               ASCII message into the UART transmitter, then enforces a gap.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_msg_scheduler
  import uart_msg_pkg::*;
#(
  parameter int GAP_CYCLES = 104,
  parameter int TIME_LEN   = c_TIME_LEN_DEF,
  parameter int ALARM_LEN  = c_ALARM_LEN_DEF
) (
  input  wire logic                 clk1mhz,
  input  wire logic                 reset,
  input  wire logic                 req_time,
  input  wire logic                 req_alarm,
  input  wire logic [7:0]           hour_bcd,
  input  wire logic [7:0]           min_bcd,
  input  wire logic [7:0]           sec_bcd,
  uart_msg_scheduler_if.master      tx,
  output logic                      busy,
  output logic [1:0]                grant
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  logic [1:0]         r_state;
  logic [1:0]         r_grant;
  logic               r_pend_time;
  logic               r_pend_alarm;
  logic [c_IDX_W-1:0] r_idx;
  logic [GAP_W-1:0]   r_gap;
  logic [7:0]         r_snap_hour;
  logic [7:0]         r_snap_min;
  logic [7:0]         r_snap_sec;
  logic [7:0]         r_tx_data;
  logic               r_tx_valid;

  logic               w_grant_alarm;
  logic               w_grant_time;
  logic               w_accept;
  logic               w_last;
  logic [c_IDX_W-1:0] w_msg_len;
  logic [c_IDX_W-1:0] w_char_idx;
  logic [7:0]         w_char_hour;
  logic [7:0]         w_char_min;
  logic [7:0]         w_char_sec;
  logic [7:0]         w_char;

  assign w_grant_alarm = (r_state == c_ST_IDLE) && r_pend_alarm;
  assign w_grant_time  = (r_state == c_ST_IDLE) && !r_pend_alarm && r_pend_time;

  assign w_accept  = r_tx_valid && tx.tx_ready;
  assign w_msg_len = (r_grant == c_GRANT_ALARM) ? c_IDX_W'(ALARM_LEN) : c_IDX_W'(TIME_LEN);
  assign w_last    = (r_idx == (w_msg_len - 1'b1));

  // LOAD formats byte 0 from the live inputs, which are the values being
  // snapshotted on that same edge; later bytes read the snapshot only.
  assign w_char_idx  = (r_state == c_ST_LOAD) ? '0 : (r_idx + 1'b1);
  assign w_char_hour = (r_state == c_ST_LOAD) ? hour_bcd : r_snap_hour;
  assign w_char_min  = (r_state == c_ST_LOAD) ? min_bcd  : r_snap_min;
  assign w_char_sec  = (r_state == c_ST_LOAD) ? sec_bcd  : r_snap_sec;

  uart_msg_char u_char (
    .grant    (r_grant),
    .index    (w_char_idx),
    .hour_bcd (w_char_hour),
    .min_bcd  (w_char_min),
    .sec_bcd  (w_char_sec),
    .char_out (w_char)
  );

  // A new pulse beats a same-edge grant clear so the message repeats.
  always_ff @(posedge clk1mhz or posedge reset) begin
    if (reset) begin
      r_pend_time  <= 1'b0;
      r_pend_alarm <= 1'b0;
    end else begin
      r_pend_time  <= req_time  | (r_pend_time  & ~w_grant_time);
      r_pend_alarm <= req_alarm | (r_pend_alarm & ~w_grant_alarm);
    end
  end

  always_ff @(posedge clk1mhz or posedge reset) begin
    if (reset) begin
      r_state     <= c_ST_IDLE;
      r_grant     <= c_GRANT_NONE;
      r_idx       <= '0;
      r_gap       <= '0;
      r_snap_hour <= 8'h00;
      r_snap_min  <= 8'h00;
      r_snap_sec  <= 8'h00;
      r_tx_data   <= 8'h00;
      r_tx_valid  <= 1'b0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (w_grant_alarm) begin
            r_grant <= c_GRANT_ALARM;
            r_state <= c_ST_LOAD;
          end else if (w_grant_time) begin
            r_grant <= c_GRANT_TIME;
            r_state <= c_ST_LOAD;
          end
        end
        c_ST_LOAD: begin
          if (r_grant == c_GRANT_TIME) begin
            r_snap_hour <= hour_bcd;
            r_snap_min  <= min_bcd;
            r_snap_sec  <= sec_bcd;
          end
          r_idx      <= '0;
          r_tx_data  <= w_char;
          r_tx_valid <= 1'b1;
          r_state    <= c_ST_SEND;
        end
        c_ST_SEND: begin
          if (w_accept) begin
            if (w_last) begin
              r_tx_valid <= 1'b0;
              r_gap      <= GAP_W'(GAP_CYCLES - 1);
              r_state    <= c_ST_GAP;
            end else begin
              r_idx     <= r_idx + 1'b1;
              r_tx_data <= w_char;
            end
          end
        end
        c_ST_GAP: begin
          if (r_gap == '0) begin
            r_grant <= c_GRANT_NONE;
            r_state <= c_ST_IDLE;
          end else begin
            r_gap <= r_gap - 1'b1;
          end
        end
        default: begin
          r_state <= c_ST_IDLE;
        end
      endcase
    end
  end

  assign tx.tx_data  = r_tx_data;
  assign tx.tx_valid = r_tx_valid;
  assign busy        = (r_state != c_ST_IDLE);
  assign grant       = r_grant;

endmodule
`default_nettype wire

// File: doc/uart_msg_scheduler.md
Name: uart_msg_scheduler

Overview:
Sequences multi-byte ASCII messages into the byte-level UART transmitter. It shares that transmitter between two requesters: a time report and an alarm report. Requests are latched and arbitrated at fixed priority, with alarm above time. The granted message is streamed byte by byte over a valid/ready handshake. The block sits between the clock state machine and the UART TX datapath, all on clk1mhz.

Parameters:
GAP_CYCLES, 104, idle clk1mhz cycles enforced after the last byte of a message before the next grant (one bit time at 9600 baud).
TIME_LEN, 10, byte count of the time message "HH:MM:SS\r\n".
ALARM_LEN, 7, byte count of the alarm message "ALARM\r\n".

Ports:
clk1mhz  in  1  system clock, 1 MHz
reset  in  1  asynchronous, active-high reset
req_time  in  1  one-cycle pulse requesting a time report
req_alarm  in  1  one-cycle pulse requesting an alarm report
hour_bcd  in  8  current hours, two BCD digits
min_bcd  in  8  current minutes, two BCD digits
sec_bcd  in  8  current seconds, two BCD digits
tx_data  out  8  byte to the UART transmitter
tx_valid  out  1  tx_data is valid
tx_ready  in  1  transmitter accepts the byte this cycle
busy  out  1  a message is in flight or the gap is running
grant  out  2  active message: 00 none, 01 time, 10 alarm

Behaviour:
- Reset (async, active-high):
  - tx_data=0, tx_valid=0, busy=0, grant=00.
  - Pending flags cleared, byte index=0, gap counter=0, state=IDLE.
  - Reset asserted mid-message aborts the message immediately; no partial resume after release.
- Request latching:
  - A pulse on req_time or req_alarm sets pend_time or pend_alarm on the next edge.
  - A repeat pulse while the same flag is already set coalesces; it is not counted.
  - A pulse arriving while that same message is in flight sets the pending flag again, so the message repeats later.
- States:
  - IDLE: if pend_alarm, go to LOAD with grant=10. Else if pend_time, go to LOAD with grant=01. Else stay in IDLE.
    - Granting clears the granted pending flag.
    - A request pulse on the same edge as a clear of the same flag wins: the flag stays set.
  - LOAD (1 cycle):
    - Snapshot hour_bcd, min_bcd and sec_bcd into internal registers (time message only).
    - Set byte index=0.
    - Drive tx_data=byte[0], tx_valid=1, then go to SEND.
  - SEND:
    - tx_valid stays high and tx_data stays stable until tx_valid && tx_ready.
    - On acceptance with index < LEN-1: increment index, present the next byte on the following cycle with tx_valid held high (back-to-back allowed).
    - On acceptance with index == LEN-1: drive tx_valid=0, load gap counter=GAP_CYCLES-1, go to GAP.
  - GAP:
    - Decrement the counter each cycle.
    - When it reaches 0, set grant=00 and go to IDLE.
    - New requests are latched during GAP but not granted until IDLE.
- busy=1 in LOAD, SEND and GAP; busy=0 only in IDLE.
- grant is held constant from LOAD through GAP.
- Byte formatting:
  - Each BCD digit maps to 8'h30 + nibble. Only nibbles 0-9 are valid; a nibble above 9 outputs 8'h3F ('?').
  - Time message bytes: H1 H0 ':' M1 M0 ':' S1 S0 0x0D 0x0A.
  - Alarm message bytes: 'A' 'L' 'A' 'R' 'M' 0x0D 0x0A.
- Latency: request pulse at cycle t gives the first tx_valid at t+3 (latch, grant/LOAD, SEND) when IDLE.
- Snapshot rule: time input changes after LOAD do not alter the in-flight message.
- tx_ready asserted while tx_valid=0 is ignored.

Decomposition:
- Shared package uart_msg_pkg holds:
  - state encoding (IDLE, LOAD, SEND, GAP);
  - grant codes;
  - ASCII constants (colon, CR, LF, '?', 'A', 'L', 'R', 'M', digit base 8'h30);
  - TIME_LEN and ALARM_LEN defaults.
- One combinational sub-module, uart_msg_char, maps (grant, index, snapshot registers) to the byte.
- The scheduler FSM, pending flags and gap counter stay in uart_msg_scheduler.

Test Plan:
- Time report with tx_ready tied 1: set hour=8'h12, min=8'h34, sec=8'h56, pulse req_time. Required tx_data sequence is 31 32 3A 33 34 3A 35 36 0D 0A on 10 consecutive cycles, then busy=1 for 104 cycles, then busy=0 and grant=00.
- Simultaneous requests: pulse req_time and req_alarm on the same cycle. Required: alarm first (41 4C 41 52 4D 0D 0A, grant=10), then after the gap the time message (grant=01).
- Backpressure: tx_ready low for 5 cycles on byte index 3. Required: tx_data=33 and tx_valid=1 stable throughout, index advances only on the ready cycle, and no bytes are lost or duplicated.
- Snapshot: change sec_bcd from 8'h56 to 8'h57 during SEND. Required: message still ends with 35 36 0D 0A.
- Coalescing: three req_time pulses while idle, then one during GAP. Required: exactly two time messages in total.
- Reset mid-message: assert reset at byte index 4. Required: tx_valid=0, busy=0, grant=00 on the same cycle, and no output after release until a new request.
